// File: rtl/mem_host_pkg.sv
// Shared types and constants for the MU0 memory override host bridge.
package mem_host_pkg;

    localparam int MEM_ADDR_W        = 16;
    localparam int MEM_DATA_W        = 16;
    localparam int TIMER_W           = 8;
    localparam int DEF_ACCESS_CYCLES = 2;
    localparam int DEF_READ_LATENCY  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Word address successor; 0xFFFF wraps to 0x0000.
    function automatic logic [MEM_ADDR_W-1:0] addr_next(input logic [MEM_ADDR_W-1:0] a);
        return a + MEM_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/mem_host_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module mem_host_timer
    import mem_host_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    output logic               done
);

    logic [TIMER_W-1:0] count;

    // Count down to zero and park there until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= {TIMER_W{1'b0}};
        end else if (load) begin
            count <= load_value;
        end else if (count != {TIMER_W{1'b0}}) begin
            count <= count - TIMER_W'(1);
        end else begin
            count <= count;
        end
    end

    assign done = (count == {TIMER_W{1'b0}});

endmodule

// File: rtl/mem_host_bridge.sv
// Host-side initiator for the MU0 memory override port.
// Optional feature: MEM_HOST_AUTOINC_EN adds cmd_autoinc and an internal address pointer.
module mem_host_bridge
    import mem_host_pkg::*;
#(
    parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
    parameter int READ_LATENCY  = DEF_READ_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [MEM_ADDR_W-1:0] cmd_addr,
    input  logic [MEM_DATA_W-1:0] cmd_wdata,
`ifdef MEM_HOST_AUTOINC_EN
    input  logic                  cmd_autoinc,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [MEM_DATA_W-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  overrideMemControl,
    output logic                  overrideMemRnW,
    output logic [MEM_ADDR_W-1:0] overrideMemAddr,
    output logic [MEM_DATA_W-1:0] overrideMemDataIn,
    input  logic [MEM_DATA_W-1:0] overrideMemDataOut
);

    // Reads whose latency exceeds the drive window spend the remainder in WAIT.
    localparam bit                 NEED_WAIT  = (READ_LATENCY > ACCESS_CYCLES);
    localparam int                 WAIT_CYC   = NEED_WAIT ? (READ_LATENCY - ACCESS_CYCLES - 1) : 0;
    localparam logic [TIMER_W-1:0] DRIVE_LOAD = TIMER_W'(ACCESS_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WAIT_LOAD  = TIMER_W'(WAIT_CYC);

    state_t                  state;
    logic                    is_write;
    logic                    timer_load;
    logic [TIMER_W-1:0]      timer_value;
    logic                    timer_done;
    logic [MEM_ADDR_W-1:0]   acc_addr;

`ifdef MEM_HOST_AUTOINC_EN
    logic [MEM_ADDR_W-1:0]   addr_ptr;

    // Autoinc commands take their address from the pointer.
    always_comb begin
        if (cmd_autoinc) begin
            acc_addr = addr_ptr;
        end else begin
            acc_addr = cmd_addr;
        end
    end
`else
    assign acc_addr = cmd_addr;
`endif

    // Timer reloads at acceptance and again when a read moves from DRIVE to WAIT.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = DRIVE_LOAD;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    timer_load  = 1'b1;
                    timer_value = DRIVE_LOAD;
                end else begin
                    timer_load  = 1'b0;
                end
            end
            DRIVE: begin
                if (timer_done && !is_write && NEED_WAIT) begin
                    timer_load  = 1'b1;
                    timer_value = WAIT_LOAD;
                end else begin
                    timer_load  = 1'b0;
                end
            end
            default: begin
                timer_load  = 1'b0;
            end
        endcase
    end

    mem_host_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    // Command sequencing FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            is_write           <= 1'b0;
            cmd_ready          <= 1'b1;
            busy               <= 1'b0;
            rsp_valid          <= 1'b0;
            rsp_rdata          <= {MEM_DATA_W{1'b0}};
            overrideMemControl <= 1'b0;
            overrideMemRnW     <= 1'b1;
            overrideMemAddr    <= {MEM_ADDR_W{1'b0}};
            overrideMemDataIn  <= {MEM_DATA_W{1'b0}};
`ifdef MEM_HOST_AUTOINC_EN
            addr_ptr           <= {MEM_ADDR_W{1'b0}};
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state              <= DRIVE;
                        is_write           <= cmd_write;
                        cmd_ready          <= 1'b0;
                        busy               <= 1'b1;
                        overrideMemControl <= 1'b1;
                        overrideMemRnW     <= ~cmd_write;
                        overrideMemAddr    <= acc_addr;
                        // Reads leave the last write data on the bus untouched.
                        if (cmd_write) begin
                            overrideMemDataIn <= cmd_wdata;
                        end else begin
                            overrideMemDataIn <= overrideMemDataIn;
                        end
`ifdef MEM_HOST_AUTOINC_EN
                        addr_ptr           <= addr_next(acc_addr);
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                DRIVE: begin
                    if (timer_done) begin
                        overrideMemControl <= 1'b0;
                        overrideMemRnW     <= 1'b1;
                        if (is_write) begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else if (NEED_WAIT) begin
                            state <= WAIT;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= overrideMemDataOut;
                        end
                    end else begin
                        state <= DRIVE;
                    end
                end
                WAIT: begin
                    if (timer_done) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= overrideMemDataOut;
                    end else begin
                        state <= WAIT;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state <= RESP;
                    end
                end
                default: begin
                    state              <= IDLE;
                    cmd_ready          <= 1'b1;
                    busy               <= 1'b0;
                    rsp_valid          <= 1'b0;
                    overrideMemControl <= 1'b0;
                    overrideMemRnW     <= 1'b1;
                end
            endcase
        end
    end

endmodule
